pending_priority_encoder: RTL
=============================

# pending_priority_encoder

Parametrised, registered successor to the 8:3 binary priority encoder. Per-input request pulses are captured into a sticky pending vector, and one index per cycle is drained through a valid/ready output stage. Selection is either fixed (highest index wins) or round-robin. The block sits between event/interrupt sources and a single consumer that must service every event exactly once, including under backpressure.

## Interface
- `N`, default 8: number of request inputs, N ≥ 2.
- `IDXW`, default `$clog2(N)`: index width. Derived; never overridden.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_i` input N: event pulses. Each bit high for one cycle means one event.
- `mode_i` input 1: 0 = fixed priority, 1 = round-robin. Sampled at every selection.
- `out_ready` input 1: consumer accepts `out_idx` this cycle.
- `out_valid` output 1: `out_idx` holds an unserviced event.
- `out_idx` output IDXW: index of the granted request.
- `pending_o` output N: current pending vector (registered).
- `none` output 1: no pending events and nothing in the output stage. This is the "NON" flag generalised.
- `overflow` output 1: one-cycle pulse when an event lands on an already-pending, non-granted bit.

## Operation
- **State**
  - `pending_q[N-1:0]`
  - output register `out_valid`/`out_idx`
  - round-robin pointer `ptr_q[IDXW-1:0]`, which holds the last granted index.
- **Load condition:** `load = (|pending_q) & (~out_valid | out_ready)`.
- **Fixed mode selection:** highest set index of `pending_q`.
- **Round-robin selection:** search starts at `ptr_q-1` and descends, wrapping from 0 to N-1. `ptr_q` itself is searched last.
  - `ptr_q` resets to 0, so the first round-robin search also starts at N-1.
- **Pointer update:** on every load, in either mode, `ptr_q <= selected index`. Switching modes therefore needs no resync.
- **Pending update:** `pending_q <= (pending_q & ~gnt) | req_i`, where `gnt` is the one-hot of the selected index when `load` is true, else 0.
  - A `req_i` bit coinciding with the grant of the same bit re-arms that bit. This is a new event, not an overflow.
- **Overflow:** `overflow <= |(req_i & pending_q & ~gnt)`. The duplicate event is dropped and the pending bit stays 1.
- **Output stage:**
  - On `load`: `out_valid <= 1` and `out_idx <= selected index`.
  - Else if `out_ready`: `out_valid <= 0`.
  - Otherwise hold.
- **`none`** is combinational: `~|pending_q & ~out_valid`.
- **Reset values:**
  - `pending_q` = 0, `out_valid` = 0, `out_idx` = 0, `ptr_q` = 0, `overflow` = 0.
  - `none` = 1 and `pending_o` = 0 as a consequence.
- **Reset mid-operation:** all state clears asynchronously. Events in flight are discarded and no output is produced after reset deasserts until a new `req_i` arrives.

## Timing
- **Latency:** `req_i` high before edge k, `pending_q` set after edge k, `out_valid` after edge k+1 (when the output stage is free). Two cycles minimum.
- **Throughput:** one index per cycle when `out_ready` is held high.
- **Handshake:**
  - A transfer occurs on an edge with `out_valid & out_ready`.
  - While `out_valid & ~out_ready`, `out_idx` is stable and `pending_q` only accumulates.
  - `out_valid` never drops without a transfer.
- **Mode change:** takes effect at the next `load`. The item already in the output stage is unaffected.
- All outputs except `none` are registered.

## Structure
- Shared header `priority_defs.vh` holds:
  - `MODE_FIXED` = 1'b0 and `MODE_RR` = 1'b1
  - a `clog2` function for pre-2005 tools.
- One combinational sub-module, `priority_pick`:
  - parameters `N` and `IDXW`; inputs `vec[N-1:0]`, `start[IDXW-1:0]` and `rr`; outputs `idx` and `any`.
  - Fixed mode is `rr` = 0, meaning search from N-1 downward.
- The top level holds only the registers, the handshake and the overflow logic.

## Test plan
- **Reset:** hold `rst_n` low with `req_i`=8'hFF and `out_ready`=1. Required: `out_valid`=0, `pending_o`=0, `none`=1, `overflow`=0. Release reset with `req_i`=0: no output.
- **Fixed walking-one (N=8):** `req_i` = 8'h01, 8'h02, … 8'h80, one pulse every 5 cycles, `out_ready`=1. Required: `out_idx` = 0..7, each valid for exactly one cycle, 2 cycles after its pulse; `none`=1 between pulses.
- **Fixed burst:** one-cycle `req_i`=8'hA5, `out_ready`=1. Required: `out_idx` 7, 5, 2, 0 on consecutive cycles, then `none`=1.
- **Round-robin vs fixed:** `mode_i`=1, pulse 8'h81. Grant 7; in the same cycle as that grant, pulse 8'h80 again. Required: next grant 0, then 7. Repeat with `mode_i`=0: required 7, 7, 0.
- **Backpressure:** `out_ready`=0, pulse 8'h06. Required: `out_idx`=2 held stable with `pending_o`=8'h02. Raise `out_ready`: transfers of 2 then 1.
- **Overflow / reset mid-op:** with bit 3 pending and `out_ready`=0, pulse 8'h08. Required: `overflow`=1 for one cycle and `pending_o` unchanged. Then drop `rst_n` while `out_valid`=1. Required: immediate clear of all outputs to reset values.

Source files
------------

// File: rtl/pending_priority_encoder_pkg.sv
// Shared definitions for the pending priority encoder: selection mode encodings
// and an integer ceil-log2 helper for deriving the index width.
package pending_priority_encoder_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pending_priority_encoder_pick.sv
// Combinational picker: descending search over vec_i, starting at N-1 (fixed) or just
// below start_i with wrap-around (round-robin, start_i itself searched last).
module pending_priority_encoder_pick
    import pending_priority_encoder_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned IDXW = clog2(N)
) (
    input  logic [N-1:0]    vec_i,
    input  logic [IDXW-1:0] start_i,
    input  logic            rr_i,
    output logic [IDXW-1:0] idx_o,
    output logic            any_o
);

    assign any_o = |vec_i;

    always_comb begin
        int unsigned     first;
        int unsigned     cand;
        logic [IDXW-1:0] cand_idx;
        logic            found;

        first = N - 1;
        if (rr_i && (start_i != '0)) begin
            first = 32'(start_i) - 1;
        end

        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // Adding N before subtracting keeps the wrap arithmetic non-negative.
            cand     = (first + N - k) % N;
            cand_idx = IDXW'(cand);
            if (!found && vec_i[cand_idx]) begin
                found = 1'b1;
                idx_o = cand_idx;
            end
        end
    end

endmodule

// File: rtl/pending_priority_encoder.sv
// Sticky pending-event capture with one-index-per-cycle drain through a registered
// valid/ready output stage; fixed or round-robin selection.
module pending_priority_encoder
    import pending_priority_encoder_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned IDXW = clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_i,
    input  logic            mode_i,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [IDXW-1:0] out_idx,
    output logic [N-1:0]    pending_o,
    output logic            none,
    output logic            overflow
);

    logic [N-1:0]    pending_q, pending_d;
    logic            out_valid_q, out_valid_d;
    logic [IDXW-1:0] out_idx_q, out_idx_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic            overflow_q, overflow_d;

    logic [IDXW-1:0] sel_idx;
    logic            sel_any;
    logic            rr_sel;
    logic            load;
    logic [N-1:0]    gnt;

    assign rr_sel = (mode_i == MODE_RR);

    pending_priority_encoder_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .vec_i   (pending_q),
        .start_i (ptr_q),
        .rr_i    (rr_sel),
        .idx_o   (sel_idx),
        .any_o   (sel_any)
    );

    always_comb begin
        load = sel_any & (~out_valid_q | out_ready);

        gnt = '0;
        if (load) begin
            gnt[sel_idx] = 1'b1;
        end

        // A request on the bit being granted this cycle re-arms it rather than overflowing.
        pending_d  = (pending_q & ~gnt) | req_i;
        overflow_d = |(req_i & pending_q & ~gnt);
        ptr_d      = load ? sel_idx : ptr_q;

        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_idx_d   = sel_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            ptr_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            ptr_q       <= ptr_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign pending_o = pending_q;
    assign overflow  = overflow_q;
    assign none      = ~|pending_q & ~out_valid_q;

    // A stalled output must hold its index until the consumer takes it.
    stall_holds_a : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_idx)));

    grant_onehot_a : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

endmodule
